wbuf_loader: RTL

WBUF_LOADER -- requirements
Module: wbuf_loader

---
 rtl/wbuf_loader.sv | 127 ++++++++++++
 1 files changed

// File: rtl/wbuf_loader.sv
// Weight-buffer loader: streams upstream memory beats into the banked weight
// buffer, buf_id fastest, starting at a configurable bank row.
module wbuf_loader #(
    parameter int ARRAY_N        = 64,
    parameter int ARRAY_M        = 64,
    parameter int DATA_WIDTH     = 16,
    parameter int MEM_DATA_WIDTH = 64,
    parameter int BUF_ADDR_WIDTH = 9,
    localparam int GROUP_SIZE     = DATA_WIDTH * ARRAY_M / MEM_DATA_WIDTH,
    localparam int GROUP_ID_W     = (GROUP_SIZE == 1) ? 0 : $clog2(GROUP_SIZE),
    localparam int BUF_ID_W       = $clog2(ARRAY_N) + GROUP_ID_W,
    localparam int NUM_BUFS       = ARRAY_N * GROUP_SIZE,
    localparam int MEM_ADDR_WIDTH = BUF_ADDR_WIDTH + BUF_ID_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_start,
    input  logic [BUF_ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [BUF_ADDR_WIDTH:0]   cfg_num_rows,
    output logic                      cfg_busy,
    output logic                      cfg_done,
    input  logic                      s_data_valid,
    output logic                      s_data_ready,
    input  logic [MEM_DATA_WIDTH-1:0] s_data,
    output logic                      mem_write_req,
    output logic [MEM_ADDR_WIDTH-1:0] mem_write_addr,
    output logic [MEM_DATA_WIDTH-1:0] mem_write_data
);

    // Counter width kept at least one bit so a single-bank build still elaborates.
    localparam int BID_CW = (BUF_ID_W == 0) ? 1 : BUF_ID_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state;
    logic [BID_CW-1:0]         buf_id;
    logic [BUF_ADDR_WIDTH:0]   row_off;
    logic [BUF_ADDR_WIDTH-1:0] row_addr;
    logic [BUF_ADDR_WIDTH:0]   num_rows_q;
    logic [MEM_ADDR_WIDTH-1:0] next_addr;
    logic                      accept;
    logic                      last_buf;
    logic                      last_row;

    generate
        if (BUF_ID_W == 0) begin : g_no_bid
            assign next_addr = row_addr;
        end else begin : g_bid
            assign next_addr = {row_addr, buf_id};
        end
    endgenerate

    assign accept   = s_data_valid && s_data_ready;
    assign last_buf = (buf_id == BID_CW'(NUM_BUFS - 1));
    assign last_row = (row_off == (num_rows_q - 1'b1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            buf_id         <= '0;
            row_off        <= '0;
            row_addr       <= '0;
            num_rows_q     <= '0;
            cfg_busy       <= 1'b0;
            cfg_done       <= 1'b0;
            s_data_ready   <= 1'b0;
            mem_write_req  <= 1'b0;
            mem_write_addr <= '0;
            mem_write_data <= '0;
        end else begin
            mem_write_req <= 1'b0;
            cfg_done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        cfg_busy <= 1'b1;
                        if (cfg_num_rows != '0) begin
                            row_addr     <= cfg_base_addr;
                            num_rows_q   <= cfg_num_rows;
                            row_off      <= '0;
                            buf_id       <= '0;
                            s_data_ready <= 1'b1;
                            state        <= LOAD;
                        end else begin
                            cfg_done <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        mem_write_req  <= 1'b1;
                        mem_write_addr <= next_addr;
                        mem_write_data <= s_data;
                        if (last_buf) begin
                            buf_id <= '0;
                            if (last_row) begin
                                s_data_ready <= 1'b0;
                                cfg_done     <= 1'b1;
                                state        <= DONE;
                            end else begin
                                row_off  <= row_off + 1'b1;
                                row_addr <= row_addr + 1'b1;
                            end
                        end else begin
                            buf_id <= buf_id + 1'b1;
                        end
                    end
                end
                DONE: begin
                    cfg_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    cfg_busy     <= 1'b0;
                    s_data_ready <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule
